// File: rtl/isr_nest_manager.sv
// isr_nest_manager
// Nested, priority-preemptive interrupt entry/exit manager. It decides whether
// a pending IRQ may preempt the running context, drives the vector or return
// PC to the core in the same cycle as the strobe, and keeps a LIFO of
// interrupted PCs and active IRQ IDs. Lower IRQ ID means higher priority.
module isr_nest_manager #(
   parameter int unsigned ID_W       = 5,
   parameter int unsigned NEST_DEPTH = 4,
   parameter logic [31:0] ISR_BASE   = 32'h1C000000,
   parameter int unsigned VEC_SHIFT  = 2,
   parameter logic [31:0] RESET_PC   = 32'h1A000000,
   localparam int unsigned LVL_W     = $clog2(NEST_DEPTH + 1)
) (
   input  logic              CLK,
   input  logic              RES,
   input  logic [31:0]       PC_READ,
   input  logic              IRQ_VALID,
   input  logic [ID_W-1:0]   IRQ_ID,
   input  logic              GLOBAL_IE,
   input  logic              ENTER_ISR,
   input  logic              EXIT_ISR,
   output logic              IRQ_TAKE,
   output logic [31:0]       PC_WRITE,
   output logic              IRQ_ACK,
   output logic [ID_W-1:0]   IRQ_ACK_ID,
   output logic [LVL_W-1:0]  NEST_LEVEL,
   output logic [ID_W-1:0]   ACTIVE_ID,
   output logic              NEST_ERR
);

   localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(NEST_DEPTH);

   // Context stack and control state
   logic [31:0]      r_pc_stk [NEST_DEPTH];
   logic [ID_W-1:0]  r_id_stk [NEST_DEPTH];
   logic [LVL_W-1:0] r_level;
   logic             r_err;

   // Decoded top-of-stack view and entry decision
   logic [31:0]      w_top_pc;
   logic [ID_W-1:0]  w_top_id;
   logic             w_empty;
   logic             w_full;
   logic             w_take;
   logic             w_accept;
   logic [31:0]      w_vec;

   assign w_empty = (r_level == '0);
   assign w_full  = (r_level >= DEPTH_L);
   assign w_vec   = ISR_BASE + (32'(IRQ_ID) << VEC_SHIFT);

   // Select the top-of-stack entry by matching level, so an empty stack
   // naturally yields zero without an out-of-range index
   always_comb begin
      w_top_pc = '0;
      w_top_id = '0;
      for (int i = 0; i < NEST_DEPTH; i++) begin
         if (r_level == LVL_W'(i + 1)) begin
            w_top_pc = r_pc_stk[i];
            w_top_id = r_id_stk[i];
         end
      end
   end

   // Preemption only by a strictly higher priority (lower ID) source;
   // equal IDs never nest on themselves
   assign w_take   = GLOBAL_IE & IRQ_VALID & ~w_full &
                     (w_empty | (IRQ_ID < w_top_id));
   assign w_accept = ENTER_ISR & w_take;

   // Zero-latency PC and acknowledge outputs; an accepted entry wins over
   // everything, otherwise the current return target (or reset PC) is shown
   always_comb begin
      PC_WRITE   = w_empty ? RESET_PC : w_top_pc;
      IRQ_ACK    = 1'b0;
      IRQ_ACK_ID = '0;
      if (w_accept) begin
         PC_WRITE   = w_vec;
         IRQ_ACK    = 1'b1;
         IRQ_ACK_ID = IRQ_ID;
      end
   end

   // Push on accepted entry, pop on a lone exit; illegal strobe combinations
   // (rejected entry, underflowing exit, simultaneous entry+exit) set the
   // sticky error flag, which only reset clears
   always_ff @(posedge CLK) begin
      if (RES) begin
         r_level <= '0;
         r_err   <= 1'b0;
         for (int i = 0; i < NEST_DEPTH; i++) begin
            r_pc_stk[i] <= '0;
            r_id_stk[i] <= '0;
         end
      end else if (ENTER_ISR) begin
         if (w_take) begin
            for (int i = 0; i < NEST_DEPTH; i++) begin
               if (r_level == LVL_W'(i)) begin
                  r_pc_stk[i] <= PC_READ;
                  r_id_stk[i] <= IRQ_ID;
               end
            end
            r_level <= r_level + 1'b1;
         end else begin
            r_err <= 1'b1;
         end
         if (EXIT_ISR) begin
            r_err <= 1'b1;
         end
      end else if (EXIT_ISR) begin
         if (w_empty) begin
            r_err <= 1'b1;
         end else begin
            r_level <= r_level - 1'b1;
         end
      end
   end

   assign IRQ_TAKE   = w_take;
   assign NEST_LEVEL = r_level;
   assign ACTIVE_ID  = w_top_id;
   assign NEST_ERR   = r_err;

endmodule

// File: tb/tb_isr_nest_manager.sv
// Directed bench for isr_nest_manager with hand-computed expectations.
module tb_isr_nest_manager;

   logic        CLK = 1'b0;
   logic        RES;
   logic [31:0] PC_READ;
   logic        IRQ_VALID;
   logic [4:0]  IRQ_ID;
   logic        GLOBAL_IE;
   logic        ENTER_ISR;
   logic        EXIT_ISR;
   logic        IRQ_TAKE;
   logic [31:0] PC_WRITE;
   logic        IRQ_ACK;
   logic [4:0]  IRQ_ACK_ID;
   logic [2:0]  NEST_LEVEL;
   logic [4:0]  ACTIVE_ID;
   logic        NEST_ERR;

   int n_checks = 0;
   int n_fail   = 0;

   isr_nest_manager dut (
      .CLK        (CLK),
      .RES        (RES),
      .PC_READ    (PC_READ),
      .IRQ_VALID  (IRQ_VALID),
      .IRQ_ID     (IRQ_ID),
      .GLOBAL_IE  (GLOBAL_IE),
      .ENTER_ISR  (ENTER_ISR),
      .EXIT_ISR   (EXIT_ISR),
      .IRQ_TAKE   (IRQ_TAKE),
      .PC_WRITE   (PC_WRITE),
      .IRQ_ACK    (IRQ_ACK),
      .IRQ_ACK_ID (IRQ_ACK_ID),
      .NEST_LEVEL (NEST_LEVEL),
      .ACTIVE_ID  (ACTIVE_ID),
      .NEST_ERR   (NEST_ERR)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // advance one edge, then settle 1 time unit past it
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      RES = 1'b1; PC_READ = '0; IRQ_VALID = 1'b0; IRQ_ID = '0;
      GLOBAL_IE = 1'b0; ENTER_ISR = 1'b0; EXIT_ISR = 1'b0;
      step(); step();
      chk("rst_pc",     PC_WRITE, 32'h1A000000);
      chk("rst_level",  32'(NEST_LEVEL), 0);
      chk("rst_active", 32'(ACTIVE_ID), 0);
      chk("rst_err",    32'(NEST_ERR), 0);
      chk("rst_ack",    32'(IRQ_ACK), 0);
      chk("rst_ackid",  32'(IRQ_ACK_ID), 0);
      GLOBAL_IE = 1'b1; IRQ_VALID = 1'b1; IRQ_ID = 5'd9; #1;
      chk("rst_take",   32'(IRQ_TAKE), 1);
      GLOBAL_IE = 1'b0; #1;
      chk("gie_off_take", 32'(IRQ_TAKE), 0);
      RES = 1'b0;
      step();

      // single entry
      GLOBAL_IE = 1'b1; IRQ_ID = 5'd3; PC_READ = 32'h1A000040; ENTER_ISR = 1'b1; #1;
      chk("e1_take",  32'(IRQ_TAKE), 1);
      chk("e1_pc",    PC_WRITE, 32'h1C00000C);
      chk("e1_ack",   32'(IRQ_ACK), 1);
      chk("e1_ackid", 32'(IRQ_ACK_ID), 3);
      step();
      ENTER_ISR = 1'b0; #1;
      chk("e1_level",  32'(NEST_LEVEL), 1);
      chk("e1_active", 32'(ACTIVE_ID), 3);
      chk("e1_idle_ack", 32'(IRQ_ACK), 0);
      chk("e1_idle_pc",  PC_WRITE, 32'h1A000040);

      // priority
      IRQ_ID = 5'd5; #1; chk("pri_lower", 32'(IRQ_TAKE), 0);
      IRQ_ID = 5'd3; #1; chk("pri_equal", 32'(IRQ_TAKE), 0);
      IRQ_ID = 5'd1; #1; chk("pri_higher", 32'(IRQ_TAKE), 1);
      PC_READ = 32'h1C000020; ENTER_ISR = 1'b1; #1;
      chk("e2_pc",    PC_WRITE, 32'h1C000004);
      chk("e2_ackid", 32'(IRQ_ACK_ID), 1);
      step();
      ENTER_ISR = 1'b0; #1;
      chk("e2_level",  32'(NEST_LEVEL), 2);
      chk("e2_active", 32'(ACTIVE_ID), 1);
      EXIT_ISR = 1'b1; #1;
      chk("x1_pc", PC_WRITE, 32'h1C000020);
      step();
      chk("x1_level",  32'(NEST_LEVEL), 1);
      chk("x1_active", 32'(ACTIVE_ID), 3);
      chk("x2_pc", PC_WRITE, 32'h1A000040);
      step();
      EXIT_ISR = 1'b0; #1;
      chk("x2_level",  32'(NEST_LEVEL), 0);
      chk("x2_active", 32'(ACTIVE_ID), 0);
      chk("x2_err",    32'(NEST_ERR), 0);

      // underflow
      EXIT_ISR = 1'b1; #1;
      chk("uf_pc", PC_WRITE, 32'h1A000000);
      step();
      EXIT_ISR = 1'b0; #1;
      chk("uf_err",   32'(NEST_ERR), 1);
      chk("uf_level", 32'(NEST_LEVEL), 0);
      RES = 1'b1; step(); RES = 1'b0; #1;
      chk("uf_clr_err", 32'(NEST_ERR), 0);

      // fill the stack with back-to-back entries
      ENTER_ISR = 1'b1;
      IRQ_ID = 5'd7; PC_READ = 32'hA0000100; #1;
      chk("f1_ackid", 32'(IRQ_ACK_ID), 7);
      step();
      IRQ_ID = 5'd5; PC_READ = 32'hA0000200; #1;
      chk("f2_ackid", 32'(IRQ_ACK_ID), 5);
      step();
      IRQ_ID = 5'd3; PC_READ = 32'hA0000300; #1;
      chk("f3_ack", 32'(IRQ_ACK), 1);
      step();
      IRQ_ID = 5'd1; PC_READ = 32'hA0000400; #1;
      chk("f4_pc", PC_WRITE, 32'h1C000004);
      step();
      ENTER_ISR = 1'b0; IRQ_ID = 5'd0; #1;
      chk("full_level",  32'(NEST_LEVEL), 4);
      chk("full_active", 32'(ACTIVE_ID), 1);
      chk("full_take",   32'(IRQ_TAKE), 0);
      ENTER_ISR = 1'b1; #1;
      chk("full_ack", 32'(IRQ_ACK), 0);
      step();
      ENTER_ISR = 1'b0; #1;
      chk("full_err",   32'(NEST_ERR), 1);
      chk("full_level2", 32'(NEST_LEVEL), 4);
      chk("full_pc",    PC_WRITE, 32'hA0000400);
      EXIT_ISR = 1'b1; step();
      chk("pop3_pc", PC_WRITE, 32'hA0000300);
      step();
      chk("pop2_pc", PC_WRITE, 32'hA0000200);
      chk("pop2_active", 32'(ACTIVE_ID), 5);
      step();
      chk("pop1_pc", PC_WRITE, 32'hA0000100);
      step();
      EXIT_ISR = 1'b0; #1;
      chk("pop_level", 32'(NEST_LEVEL), 0);

      // simultaneous strobes
      RES = 1'b1; step(); RES = 1'b0;
      IRQ_ID = 5'd2; PC_READ = 32'h12345678; ENTER_ISR = 1'b1; EXIT_ISR = 1'b1; #1;
      chk("both_pc",  PC_WRITE, 32'h1C000008);
      chk("both_ack", 32'(IRQ_ACK), 1);
      step();
      ENTER_ISR = 1'b0; EXIT_ISR = 1'b0; #1;
      chk("both_level",  32'(NEST_LEVEL), 1);
      chk("both_active", 32'(ACTIVE_ID), 2);
      chk("both_err",    32'(NEST_ERR), 1);
      chk("both_retpc",  PC_WRITE, 32'h12345678);

      // reset mid-nesting, with an entry in the same cycle
      RES = 1'b1; step(); RES = 1'b0;
      ENTER_ISR = 1'b1;
      IRQ_ID = 5'd6; step();
      IRQ_ID = 5'd4; step();
      IRQ_ID = 5'd2; step();
      ENTER_ISR = 1'b0; #1;
      chk("mid_level", 32'(NEST_LEVEL), 3);
      RES = 1'b1; ENTER_ISR = 1'b1; IRQ_ID = 5'd1; step();
      RES = 1'b0; ENTER_ISR = 1'b0; #1;
      chk("mid_rst_level",  32'(NEST_LEVEL), 0);
      chk("mid_rst_err",    32'(NEST_ERR), 0);
      chk("mid_rst_pc",     PC_WRITE, 32'h1A000000);
      chk("mid_rst_active", 32'(ACTIVE_ID), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
